// File: rtl/rw_arb_pkg.sv
// rw_arb_pkg: shared constants for the cache/arbiter link.
//   - Tag field offsets for the 13-bit tag {rw[12], type[11:8], src[7], seq[6:0]}
//   - rw encodings (READ/WRITE), request types (MEMORY/MMIO/PORT/IRQ)
//   - source encodings (DATA/INSTR) carried in the tag src bit
//   - arbiter FSM state enum
package rw_arb_pkg;

    localparam int unsigned TAG_RW      = 12;
    localparam int unsigned TAG_TYPE_HI = 11;
    localparam int unsigned TAG_TYPE_LO = 8;
    localparam int unsigned TAG_SRC     = 7;
    localparam int unsigned TAG_SEQ_HI  = 6;
    localparam int unsigned TAG_SEQ_LO  = 0;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam logic [3:0] MEMORY = 4'd0;
    localparam logic [3:0] MMIO   = 4'd1;
    localparam logic [3:0] PORT   = 4'd2;
    localparam logic [3:0] IRQ    = 4'd3;

    localparam logic DATA  = 1'b1;
    localparam logic INSTR = 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_e;

endpackage

// File: rtl/rw_arb_select.sv
// rw_arb_select: picks which client is granted when the arbiter is idle.
// Configuration macro: RW_ARB_ROUND_ROBIN_EN
//   defined   - ties alternate; after reset data wins first, then the
//               last-granted client loses the next tie.
//   undefined - data always wins ties (purely combinational, no state).
// Ports:
//   clk, reset, grant_en   (round-robin build only) pointer clock/reset/advance
//   i_reqcyc, d_reqcyc     client request valids
//   grant_valid            some client is requesting
//   grant_src              DATA or INSTR, meaningful when grant_valid
module rw_arb_select (
`ifdef RW_ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic reset,
    input  logic grant_en,
`endif
    input  logic i_reqcyc,
    input  logic d_reqcyc,
    output logic grant_valid,
    output logic grant_src
);
    import rw_arb_pkg::*;

    assign grant_valid = i_reqcyc | d_reqcyc;

`ifdef RW_ARB_ROUND_ROBIN_EN
    logic favour_d;

    // Every grant moves the preference to the other client.
    always_ff @(posedge clk) begin
        if (reset) begin
            favour_d <= 1'b1;
        end else if (grant_en) begin
            favour_d <= (grant_src == INSTR);
        end
    end

    always_comb begin
        if (i_reqcyc && d_reqcyc) begin
            grant_src = favour_d ? DATA : INSTR;
        end else begin
            grant_src = d_reqcyc ? DATA : INSTR;
        end
    end
`else
    assign grant_src = d_reqcyc ? DATA : INSTR;
`endif

endmodule

// File: rtl/rw_cache_arbiter.sv
// rw_cache_arbiter: requester-side end of the cache/arbiter link.
// Grants one of the instruction-fetch (i_*) or data (d_*) clients at a time,
// issues its request to the cache and routes response beats back by tag src.
// Configuration macro: RW_ARB_ROUND_ROBIN_EN (tie-break policy, see rw_arb_select).
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   i_/d_reqcyc, _req, _reqtag    client requests (d_reqdata: write data)
//   i_/d_reqack                   one-cycle accept pulse
//   i_/d_respcyc, _resp, _resptag registered response beats
//   d_writeack                    one-cycle write-complete pulse
//   req, reqdata, reqtag, reqcyc  cache request (held until reqack)
//   reqack                        cache accepted request
//   resp, resptag, respcyc        cache response beat
//   respack                       beat accepted (combinational)
module rw_cache_arbiter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TAG_WIDTH  = 13,
    parameter int unsigned BEATS      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_reqcyc,
    input  logic [DATA_WIDTH-1:0] i_req,
    input  logic [TAG_WIDTH-1:0]  i_reqtag,
    output logic                  i_reqack,
    output logic                  i_respcyc,
    output logic [DATA_WIDTH-1:0] i_resp,
    output logic [TAG_WIDTH-1:0]  i_resptag,
    input  logic                  d_reqcyc,
    input  logic [DATA_WIDTH-1:0] d_req,
    input  logic [DATA_WIDTH-1:0] d_reqdata,
    input  logic [TAG_WIDTH-1:0]  d_reqtag,
    output logic                  d_reqack,
    output logic                  d_respcyc,
    output logic [DATA_WIDTH-1:0] d_resp,
    output logic [TAG_WIDTH-1:0]  d_resptag,
    output logic                  d_writeack,
    output logic [DATA_WIDTH-1:0] req,
    output logic [DATA_WIDTH-1:0] reqdata,
    output logic [TAG_WIDTH-1:0]  reqtag,
    output logic                  reqcyc,
    input  logic                  reqack,
    input  logic [DATA_WIDTH-1:0] resp,
    input  logic [TAG_WIDTH-1:0]  resptag,
    input  logic                  respcyc,
    output logic                  respack
);
    import rw_arb_pkg::*;

    localparam int unsigned      CNT_W     = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_e               state;
    logic [CNT_W-1:0]     beat_cnt;
    logic                 grant_valid;
    logic                 grant_src;
    logic [TAG_WIDTH-1:0] i_tag_fixed;
    logic [TAG_WIDTH-1:0] d_tag_fixed;

`ifdef RW_ARB_ROUND_ROBIN_EN
    logic grant_en;
    assign grant_en = (state == StIdle) && grant_valid;
`endif

    rw_arb_select u_select (
`ifdef RW_ARB_ROUND_ROBIN_EN
        .clk         (clk),
        .reset       (reset),
        .grant_en    (grant_en),
`endif
        .i_reqcyc    (i_reqcyc),
        .d_reqcyc    (d_reqcyc),
        .grant_valid (grant_valid),
        .grant_src   (grant_src)
    );

    // Clients cannot spoof the source bit; fetch is always a read.
    always_comb begin
        i_tag_fixed          = i_reqtag;
        i_tag_fixed[TAG_SRC] = INSTR;
        i_tag_fixed[TAG_RW]  = READ;
        d_tag_fixed          = d_reqtag;
        d_tag_fixed[TAG_SRC] = DATA;
    end

    assign respack = (state == StResp) && respcyc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            beat_cnt   <= '0;
            req        <= '0;
            reqdata    <= '0;
            reqtag     <= '0;
            reqcyc     <= 1'b0;
            i_reqack   <= 1'b0;
            d_reqack   <= 1'b0;
            d_writeack <= 1'b0;
            i_respcyc  <= 1'b0;
            i_resp     <= '0;
            i_resptag  <= '0;
            d_respcyc  <= 1'b0;
            d_resp     <= '0;
            d_resptag  <= '0;
        end else begin
            // Pulse outputs default low every cycle.
            i_reqack   <= 1'b0;
            d_reqack   <= 1'b0;
            d_writeack <= 1'b0;
            i_respcyc  <= 1'b0;
            d_respcyc  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (grant_valid) begin
                        state  <= StIssue;
                        reqcyc <= 1'b1;
                        if (grant_src == DATA) begin
                            req      <= d_req;
                            reqdata  <= d_reqdata;
                            reqtag   <= d_tag_fixed;
                            d_reqack <= 1'b1;
                        end else begin
                            req      <= i_req;
                            reqdata  <= '0;
                            reqtag   <= i_tag_fixed;
                            i_reqack <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (reqack) begin
                        reqcyc <= 1'b0;
                        if (reqtag[TAG_RW] == WRITE) begin
                            d_writeack <= 1'b1;
                            state      <= StIdle;
                        end else begin
                            beat_cnt <= '0;
                            state    <= StResp;
                        end
                    end
                end
                StResp: begin
                    if (respcyc) begin
                        // Routed by the beat's own src bit, even on a tag mismatch.
                        if (resptag[TAG_SRC] == DATA) begin
                            d_respcyc <= 1'b1;
                            d_resp    <= resp;
                            d_resptag <= resptag;
                        end else begin
                            i_respcyc <= 1'b1;
                            i_resp    <= resp;
                            i_resptag <= resptag;
                        end
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifndef SYNTHESIS
    resp_tag_match_a: assert property (@(posedge clk) disable iff (reset)
        (state == StResp && respcyc) |-> (resptag == reqtag))
        else $error("rw_cache_arbiter: response tag differs from outstanding request tag");
`endif

endmodule

// File: tb/tb_rw_cache_arbiter.sv
module tb_rw_cache_arbiter;

    localparam int unsigned DW = 64;
    localparam int unsigned TW = 13;

    logic          clk;
    logic          reset;
    logic          i_reqcyc;
    logic [DW-1:0] i_req;
    logic [TW-1:0] i_reqtag;
    logic          i_reqack;
    logic          i_respcyc;
    logic [DW-1:0] i_resp;
    logic [TW-1:0] i_resptag;
    logic          d_reqcyc;
    logic [DW-1:0] d_req;
    logic [DW-1:0] d_reqdata;
    logic [TW-1:0] d_reqtag;
    logic          d_reqack;
    logic          d_respcyc;
    logic [DW-1:0] d_resp;
    logic [TW-1:0] d_resptag;
    logic          d_writeack;
    logic [DW-1:0] req;
    logic [DW-1:0] reqdata;
    logic [TW-1:0] reqtag;
    logic          reqcyc;
    logic          reqack;
    logic [DW-1:0] resp;
    logic [TW-1:0] resptag;
    logic          respcyc;
    logic          respack;

    int n_checks;
    int n_fail;

    rw_cache_arbiter #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW),
        .BEATS      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_reqcyc   (i_reqcyc),
        .i_req      (i_req),
        .i_reqtag   (i_reqtag),
        .i_reqack   (i_reqack),
        .i_respcyc  (i_respcyc),
        .i_resp     (i_resp),
        .i_resptag  (i_resptag),
        .d_reqcyc   (d_reqcyc),
        .d_req      (d_req),
        .d_reqdata  (d_reqdata),
        .d_reqtag   (d_reqtag),
        .d_reqack   (d_reqack),
        .d_respcyc  (d_respcyc),
        .d_resp     (d_resp),
        .d_resptag  (d_resptag),
        .d_writeack (d_writeack),
        .req        (req),
        .reqdata    (reqdata),
        .reqtag     (reqtag),
        .reqcyc     (reqcyc),
        .reqack     (reqack),
        .resp       (resp),
        .resptag    (resptag),
        .respcyc    (respcyc),
        .respack    (respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_reqcyc  = 1'b0;
        i_req     = '0;
        i_reqtag  = '0;
        d_reqcyc  = 1'b0;
        d_req     = '0;
        d_reqdata = '0;
        d_reqtag  = '0;
        reqack    = 1'b0;
        resp      = '0;
        resptag   = '0;
        respcyc   = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Drives eight back-to-back cache beats carrying the given tag.
    task automatic feed_beats(input logic [TW-1:0] tag);
        for (int b = 0; b < 8; b++) begin
            respcyc = 1'b1;
            resp    = DW'(b);
            resptag = tag;
            tick();
        end
        respcyc = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({reqcyc, i_reqack, d_reqack, i_respcyc, d_respcyc, d_writeack, respack} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {reqcyc, i_reqack, d_reqack, i_respcyc, d_respcyc, d_writeack, respack});
        end
        n_checks++;
        if ({req, reqdata, reqtag} !== '0) begin
            n_fail++;
            $display("FAIL reset_req: got req=%h data=%h tag=%h want all 0", req, reqdata, reqtag);
        end
        n_checks++;
        if ({i_resp, i_resptag, d_resp, d_resptag} !== '0) begin
            n_fail++;
            $display("FAIL reset_resp: got i=%h/%h d=%h/%h want all 0",
                     i_resp, i_resptag, d_resp, d_resptag);
        end
    endtask

    task automatic test_i_read();
        // Client tag has src=1, rw=0: both must be overwritten.
        i_reqcyc = 1'b1;
        i_req    = 64'h1000;
        i_reqtag = 13'h085;
        tick();
        n_checks++;
        if ({reqcyc, i_reqack, d_reqack} !== 3'b110 || req !== 64'h1000 || reqtag !== 13'h1005) begin
            n_fail++;
            $display("FAIL iread_issue: got cyc/iack/dack=%b req=%h tag=%h want 110 1000 1005",
                     {reqcyc, i_reqack, d_reqack}, req, reqtag);
        end
        i_reqcyc = 1'b0;
        reqack   = 1'b1;
        tick();
        reqack = 1'b0;
        n_checks++;
        if ({reqcyc, i_reqack, d_writeack} !== 3'b000) begin
            n_fail++;
            $display("FAIL iread_accepted: got cyc/iack/wack=%b want 000",
                     {reqcyc, i_reqack, d_writeack});
        end
        for (int b = 0; b < 8; b++) begin
            respcyc = 1'b1;
            resp    = DW'(b);
            resptag = 13'h1005;
            #1;
            n_checks++;
            if (respack !== 1'b1) begin
                n_fail++;
                $display("FAIL iread_respack beat %0d: got %b want 1", b, respack);
            end
            tick();
            n_checks++;
            if (i_respcyc !== 1'b1 || d_respcyc !== 1'b0 || i_resp !== DW'(b)
                || i_resptag !== 13'h1005) begin
                n_fail++;
                $display("FAIL iread_beat %0d: got i_cyc=%b d_cyc=%b data=%h tag=%h want 1 0 %h 1005",
                         b, i_respcyc, d_respcyc, i_resp, i_resptag, b);
            end
        end
        // A ninth beat must be refused: the FSM is back in idle.
        resp = 64'hFF;
        #1;
        n_checks++;
        if (respack !== 1'b0) begin
            n_fail++;
            $display("FAIL iread_extra_beat_respack: got %b want 0", respack);
        end
        tick();
        respcyc = 1'b0;
        n_checks++;
        if (i_respcyc !== 1'b0) begin
            n_fail++;
            $display("FAIL iread_extra_beat_fwd: got %b want 0", i_respcyc);
        end
    endtask

    task automatic test_d_write();
        d_reqcyc  = 1'b1;
        d_req     = 64'h2000;
        d_reqdata = 64'hDEADBEEF;
        d_reqtag  = 13'h109;
        tick();
        n_checks++;
        if ({reqcyc, d_reqack, i_reqack} !== 3'b110 || req !== 64'h2000
            || reqdata !== 64'hDEADBEEF || reqtag !== 13'h189) begin
            n_fail++;
            $display("FAIL dwrite_issue: got cyc/dack/iack=%b req=%h data=%h tag=%h want 110 2000 deadbeef 189",
                     {reqcyc, d_reqack, i_reqack}, req, reqdata, reqtag);
        end
        d_reqcyc = 1'b0;
        reqack   = 1'b1;
        tick();
        reqack = 1'b0;
        n_checks++;
        if ({reqcyc, d_writeack, d_reqack} !== 3'b010) begin
            n_fail++;
            $display("FAIL dwrite_ack: got cyc/wack/dack=%b want 010", {reqcyc, d_writeack, d_reqack});
        end
        respcyc = 1'b1;
        resptag = 13'h189;
        #1;
        n_checks++;
        if (respack !== 1'b0) begin
            n_fail++;
            $display("FAIL dwrite_respack: got %b want 0", respack);
        end
        tick();
        respcyc = 1'b0;
        n_checks++;
        if ({d_writeack, d_respcyc, i_respcyc} !== 3'b000) begin
            n_fail++;
            $display("FAIL dwrite_after: got wack/dresp/iresp=%b want 000",
                     {d_writeack, d_respcyc, i_respcyc});
        end
    endtask

    task automatic test_arbitration();
        logic [3:0] exp_d;
`ifdef RW_ARB_ROUND_ROBIN_EN
        exp_d = 4'b0101;
`else
        exp_d = 4'b1111;
`endif
        apply_reset();
        i_reqcyc  = 1'b1;
        i_req     = 64'h3000;
        i_reqtag  = 13'h003;
        d_reqcyc  = 1'b1;
        d_req     = 64'h4000;
        d_reqdata = 64'h55;
        d_reqtag  = 13'h000;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (d_reqack !== exp_d[k] || i_reqack !== !exp_d[k]) begin
                n_fail++;
                $display("FAIL arb_grant %0d: got dack=%b iack=%b want dack=%b iack=%b",
                         k, d_reqack, i_reqack, exp_d[k], !exp_d[k]);
            end
            reqack = 1'b1;
            tick();
            reqack = 1'b0;
            if (!exp_d[k]) begin
                feed_beats(13'h1003);
            end
        end
        i_reqcyc = 1'b0;
        d_reqcyc = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_stall();
        d_reqcyc  = 1'b1;
        d_req     = 64'h5000;
        d_reqdata = 64'h123456789ABCDEF0;
        d_reqtag  = 13'h025;
        tick();
        // Disturb client inputs; the cache-side request must not follow them.
        d_reqcyc  = 1'b0;
        d_req     = 64'hFFFF;
        d_reqdata = '0;
        d_reqtag  = 13'h1FFF;
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (reqcyc !== 1'b1 || req !== 64'h5000 || reqdata !== 64'h123456789ABCDEF0
                || reqtag !== 13'h0A5) begin
                n_fail++;
                $display("FAIL stall_hold cycle %0d: got cyc=%b req=%h data=%h tag=%h want 1 5000 123456789abcdef0 0a5",
                         c, reqcyc, req, reqdata, reqtag);
            end
            tick();
        end
        reqack = 1'b1;
        tick();
        reqack = 1'b0;
        n_checks++;
        if ({reqcyc, d_writeack} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_release: got cyc/wack=%b want 01", {reqcyc, d_writeack});
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        int pulses;
        i_reqcyc = 1'b1;
        i_req    = 64'h6000;
        i_reqtag = 13'h007;
        tick();
        i_reqcyc = 1'b0;
        reqack   = 1'b1;
        tick();
        reqack = 1'b0;
        for (int b = 0; b < 3; b++) begin
            respcyc = 1'b1;
            resp    = 64'hA0 + DW'(b);
            resptag = 13'h1007;
            tick();
        end
        respcyc = 1'b0;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({reqcyc, i_reqack, d_reqack, i_respcyc, d_respcyc, d_writeack} !== 6'b0
            || {req, reqtag, i_resp, i_resptag} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ctrl=%b req=%h tag=%h iresp=%h itag=%h want all 0",
                     {reqcyc, i_reqack, d_reqack, i_respcyc, d_respcyc, d_writeack},
                     req, reqtag, i_resp, i_resptag);
        end
        respcyc = 1'b1;
        resptag = 13'h1007;
        #1;
        n_checks++;
        if (respack !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_respack: got %b want 0", respack);
        end
        respcyc  = 1'b0;
        i_reqcyc = 1'b1;
        i_req    = 64'h7000;
        i_reqtag = 13'h008;
        tick();
        n_checks++;
        if (i_reqack !== 1'b1 || req !== 64'h7000 || reqtag !== 13'h1008) begin
            n_fail++;
            $display("FAIL midreset_reissue: got iack=%b req=%h tag=%h want 1 7000 1008",
                     i_reqack, req, reqtag);
        end
        i_reqcyc = 1'b0;
        reqack   = 1'b1;
        tick();
        reqack = 1'b0;
        pulses = 0;
        for (int b = 0; b < 8; b++) begin
            respcyc = 1'b1;
            resp    = 64'd100 + DW'(b);
            resptag = 13'h1008;
            tick();
            if (i_respcyc === 1'b1 && i_resp === 64'd100 + DW'(b)) begin
                pulses++;
            end
        end
        n_checks++;
        if (pulses !== 8) begin
            n_fail++;
            $display("FAIL midreset_beats: got %0d good beats want 8", pulses);
        end
        resp = 64'd200;
        #1;
        n_checks++;
        if (respack !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle_after: got respack=%b want 0", respack);
        end
        respcyc = 1'b0;
        tick();
    endtask

    task automatic test_resp_idle();
        logic [TW-1:0] tags [2];
        tags[0] = 13'h1080;
        tags[1] = 13'h1000;
        for (int t = 0; t < 2; t++) begin
            respcyc = 1'b1;
            resp    = 64'hAA;
            resptag = tags[t];
            #1;
            n_checks++;
            if (respack !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_respack tag %h: got %b want 0", tags[t], respack);
            end
            tick();
            n_checks++;
            if ({i_respcyc, d_respcyc} !== 2'b00) begin
                n_fail++;
                $display("FAIL idle_forward tag %h: got i/d respcyc=%b want 00",
                         tags[t], {i_respcyc, d_respcyc});
            end
        end
        respcyc = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        clear_inputs();
        test_reset();
        test_i_read();
        test_d_write();
        test_arbitration();
        test_stall();
        test_reset_mid_read();
        test_resp_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
